// File: rtl/keys_debounce_if.sv
// keys_debounce_if: raw key levels in, debounced levels and key event pulses out
interface keys_debounce_if #(
    parameter int KEYS_W = 2
);
    logic [KEYS_W-1:0] keys_i;
    logic [KEYS_W-1:0] keys_o;
    logic [KEYS_W-1:0] press_o;
    logic [KEYS_W-1:0] release_o;
    logic [KEYS_W-1:0] repeat_o;
    modport master (output keys_i, input keys_o, press_o, release_o, repeat_o);
    modport slave  (input keys_i, output keys_o, press_o, release_o, repeat_o);
endinterface

// File: rtl/keys_debounce.sv
// keys_debounce: per-key synchronizer, stability debouncer, press/release pulses and auto-repeat
module keys_debounce #(
    parameter int KEYS_W              = 2,
    parameter int DEBOUNCE_CYCLES     = 252_000,
    parameter int REPEAT_DELAY_CYCLES = 12_600_000,
    parameter int REPEAT_RATE_CYCLES  = 2_520_000
) (
    input logic            clk_i,
    input logic            rst_i,
    keys_debounce_if.slave bus
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_CYCLES - 1);

    if (KEYS_W < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_params
        $fatal(1, "keys_debounce: KEYS_W and all *_CYCLES parameters must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [KEYS_W-1:0] meta_q;
    logic [KEYS_W-1:0] sync_q;
    logic [KEYS_W-1:0] level;
    logic [KEYS_W-1:0] tgl;
    logic [KEYS_W-1:0] rise;
    logic [KEYS_W-1:0] fall;
    logic [KEYS_W-1:0] press_q;
    logic [KEYS_W-1:0] release_q;
    logic [KEYS_W-1:0] repeat_q;
    logic [CW-1:0]     cnt   [KEYS_W];
    logic [RW-1:0]     rcnt  [KEYS_W];
    state_t            state [KEYS_W];

    // bring the asynchronous key levels into the clock domain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= bus.keys_i;
            sync_q <= meta_q;
        end
    end

    // a key changes level on the last cycle of an unbroken run of disagreement
    always_comb begin
        for (int k = 0; k < KEYS_W; k++) tgl[k] = (sync_q[k] != level[k]) && (cnt[k] == DEB_LAST);
    end

    assign rise = tgl & ~level;
    assign fall = tgl & level;

    // stability counters, debounced level and edge pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int k = 0; k < KEYS_W; k++) cnt[k] <= '0;
        end else begin
            level     <= level ^ tgl;
            press_q   <= rise;
            release_q <= fall;
            for (int k = 0; k < KEYS_W; k++) cnt[k] <= (sync_q[k] == level[k] || tgl[k]) ? '0 : cnt[k] + 1'b1;
        end
    end

    // auto-repeat: pulse on press, after the hold delay, then at the repeat rate; release always wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            repeat_q <= '0;
            for (int k = 0; k < KEYS_W; k++) begin
                state[k] <= IDLE;
                rcnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < KEYS_W; k++) begin
                repeat_q[k] <= 1'b0;
                if (fall[k]) begin
                    state[k] <= IDLE;
                    rcnt[k]  <= '0;
                end else begin
                    case (state[k])
                        IDLE: begin
                            rcnt[k] <= '0;
                            if (rise[k]) begin
                                state[k]    <= DELAY;
                                repeat_q[k] <= 1'b1;
                            end
                        end
                        DELAY: begin
                            if (rcnt[k] == DLY_LAST) begin
                                state[k]    <= REPEAT;
                                rcnt[k]     <= '0;
                                repeat_q[k] <= 1'b1;
                            end else begin
                                rcnt[k] <= rcnt[k] + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rcnt[k] == RATE_LAST) begin
                                rcnt[k]     <= '0;
                                repeat_q[k] <= 1'b1;
                            end else begin
                                rcnt[k] <= rcnt[k] + 1'b1;
                            end
                        end
                        default: begin
                            state[k] <= IDLE;
                            rcnt[k]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.keys_o    = level;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.repeat_o  = repeat_q;
endmodule
